// File: rtl/hazard_fwd_unit.sv
// Hazard/forwarding controller: EX/MEM/WB shadow pipeline, ALU forwarding selects, load-use stall FSM.
// Optional macro FWD_MEM2MEM_EN enables WB->MEM store-data forwarding and skips store-data stalls.
module hazard_fwd_unit #(
  parameter int unsigned REG_AW     = 4,
  parameter int unsigned LOAD_STALL = 1,
  parameter bit          R0_ZERO    = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_src1,
  input  logic [REG_AW-1:0] id_src2,
  input  logic              id_use_src2,
  input  logic [REG_AW-1:0] id_dst,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              id_memwrite,
  input  logic              flush,
  output logic              stall,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              fwd_mem
);

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] src1;
    logic [REG_AW-1:0] src2;
    logic              use2;
    logic [REG_AW-1:0] dst;
    logic              regwrite;
    logic              memread;
    logic              memwrite;
  } stage_t;

  typedef enum logic {StIdle, StStall} state_e;

  // The detection cycle is itself the first stall cycle; StStall covers the remaining ones.
  localparam logic [1:0] CntInit = (LOAD_STALL > 1) ? 2'(LOAD_STALL - 2) : 2'd0;

  stage_t ex_q, mem_q, wb_q, id_rec;
  state_e state_q;
  logic [1:0] cnt_q;
  logic src2_hz, load_use;

  function automatic logic match(stage_t st, logic [REG_AW-1:0] s);
    return st.valid && st.regwrite && (s == st.dst) && !(R0_ZERO && (st.dst == '0));
  endfunction

  always_comb begin
    id_rec          = '0;
    id_rec.valid    = id_valid;
    id_rec.src1     = id_src1;
    id_rec.src2     = id_src2;
    id_rec.use2     = id_use_src2;
    id_rec.dst      = id_dst;
    id_rec.regwrite = id_regwrite;
    id_rec.memread  = id_memread;
    id_rec.memwrite = id_memwrite;
  end

`ifdef FWD_MEM2MEM_EN
  assign src2_hz = id_use_src2 && !id_memwrite && match(ex_q, id_src2);
  assign fwd_mem = mem_q.valid && mem_q.memwrite && wb_q.memread && match(wb_q, mem_q.src2);
`else
  assign src2_hz = id_use_src2 && match(ex_q, id_src2);
  assign fwd_mem = 1'b0;
`endif

  assign load_use = ex_q.valid && ex_q.memread && (match(ex_q, id_src1) || src2_hz);
  assign stall    = !flush && ((state_q == StStall) || (load_use && id_valid));

  always_comb begin
    fwd_a = 2'b00;
    if (match(mem_q, ex_q.src1))     fwd_a = 2'b10;
    else if (match(wb_q, ex_q.src1)) fwd_a = 2'b01;
    fwd_b = 2'b00;
    if (ex_q.use2) begin
      if (match(mem_q, ex_q.src2))     fwd_b = 2'b10;
      else if (match(wb_q, ex_q.src2)) fwd_b = 2'b01;
    end
  end

  // Bubbles are all-zero so stale register numbers never leak into forwarding.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      ex_q  <= (id_valid && !stall && !flush) ? id_rec : '0;
      mem_q <= ex_q;
      wb_q  <= mem_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      state_q <= StIdle;
      cnt_q   <= 2'd0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (load_use && id_valid && (LOAD_STALL > 1)) begin
            state_q <= StStall;
            cnt_q   <= CntInit;
          end
        end
        StStall: begin
          if (cnt_q == 2'd0) state_q <= StIdle;
          else               cnt_q   <= cnt_q - 2'd1;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  logic unused_bits;
  assign unused_bits = ^{ex_q, mem_q, wb_q, id_memwrite};

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Bench for hazard_fwd_unit: two instances (LOAD_STALL 1 and 3) against a behavioural pipeline model.
// Directed scenarios followed by randomized instruction streams with flushes and resets.
module tb_hazard_fwd_unit;

  typedef struct packed {
    logic       v;
    logic [3:0] s1;
    logic [3:0] s2;
    logic       u2;
    logic [3:0] d;
    logic       rw;
    logic       mr;
    logic       mw;
  } rec_t;

`ifdef FWD_MEM2MEM_EN
  localparam bit M2M = 1'b1;
`else
  localparam bit M2M = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic id_valid = 1'b0, id_use_src2 = 1'b0, id_regwrite = 1'b0;
  logic id_memread = 1'b0, id_memwrite = 1'b0, flush = 1'b0;
  logic [3:0] id_src1 = '0, id_src2 = '0, id_dst = '0;
  logic       stall_o [2];
  logic [1:0] fa_o [2];
  logic [1:0] fb_o [2];
  logic       fm_o [2];

  always #5 clk = ~clk;

  hazard_fwd_unit #(.REG_AW(4), .LOAD_STALL(1), .R0_ZERO(1'b1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
    .id_use_src2(id_use_src2), .id_dst(id_dst), .id_regwrite(id_regwrite),
    .id_memread(id_memread), .id_memwrite(id_memwrite), .flush(flush),
    .stall(stall_o[0]), .fwd_a(fa_o[0]), .fwd_b(fb_o[0]), .fwd_mem(fm_o[0])
  );

  hazard_fwd_unit #(.REG_AW(4), .LOAD_STALL(3), .R0_ZERO(1'b1)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
    .id_use_src2(id_use_src2), .id_dst(id_dst), .id_regwrite(id_regwrite),
    .id_memread(id_memread), .id_memwrite(id_memwrite), .flush(flush),
    .stall(stall_o[1]), .fwd_a(fa_o[1]), .fwd_b(fb_o[1]), .fwd_mem(fm_o[1])
  );

  // Model: per instance, the three in-flight instructions (0=EX,1=MEM,2=WB) and stall cycles left.
  rec_t pipe [2][3];
  int   stall_left [2];
  int   ls [2] = '{1, 3};
  int   n_cmp = 0;
  int   n_fail = 0;
  logic last_stall = 1'b0;

  function automatic logic writes(rec_t r, logic [3:0] s);
    return r.v && r.rw && (r.d == s) && (s != 4'd0);
  endfunction

  function automatic logic [1:0] src_sel(int i, logic [3:0] s, logic en);
    if (!en) return 2'd0;
    if (writes(pipe[i][1], s)) return 2'd2;
    if (writes(pipe[i][2], s)) return 2'd1;
    return 2'd0;
  endfunction

  function automatic rec_t alu(int d, int a, int b);
    rec_t r = '0;
    r.v = 1'b1; r.s1 = 4'(a); r.s2 = 4'(b); r.u2 = 1'b1; r.d = 4'(d); r.rw = 1'b1;
    return r;
  endfunction

  function automatic rec_t ld(int d, int base);
    rec_t r = '0;
    r.v = 1'b1; r.s1 = 4'(base); r.d = 4'(d); r.rw = 1'b1; r.mr = 1'b1;
    return r;
  endfunction

  function automatic rec_t st(int base, int data);
    rec_t r = '0;
    r.v = 1'b1; r.s1 = 4'(base); r.s2 = 4'(data); r.u2 = 1'b1; r.mw = 1'b1;
    return r;
  endfunction

  function automatic rec_t rnd_instr();
    rec_t r;
    int   k = int'($urandom_range(0, 9));
    int   a = int'($urandom_range(0, 3));
    int   b = int'($urandom_range(0, 3));
    int   d = int'($urandom_range(0, 3));
    if (k <= 5)      r = alu(d, a, b);
    else if (k <= 7) r = ld(d, a);
    else             r = st(a, b);
    if (k == 0) r.v = 1'b0;
    return r;
  endfunction

  task automatic chk(string tag, logic [1:0] obs, logic [1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(logic r, logic f, rec_t in);
    logic hz, e_stall, e_fm;
    rec_t ex, mem, wb;
    @(negedge clk);
    rst_n = r; flush = f;
    id_valid = in.v; id_src1 = in.s1; id_src2 = in.s2; id_use_src2 = in.u2;
    id_dst = in.d; id_regwrite = in.rw; id_memread = in.mr; id_memwrite = in.mw;
    #1;
    last_stall = 1'b0;
    for (int i = 0; i < 2; i++) begin
      ex = pipe[i][0]; mem = pipe[i][1]; wb = pipe[i][2];
      hz = ex.v && ex.mr &&
           (writes(ex, in.s1) || (in.u2 && writes(ex, in.s2) && !(M2M && in.mw)));
      e_stall = !f && ((stall_left[i] > 0) || (hz && in.v));
      e_fm = M2M && mem.v && mem.mw && wb.mr && writes(wb, mem.s2);
      chk($sformatf("stall[ls=%0d]", ls[i]), {1'b0, stall_o[i]}, {1'b0, e_stall});
      chk($sformatf("fwd_a[ls=%0d]", ls[i]), fa_o[i], src_sel(i, ex.s1, 1'b1));
      chk($sformatf("fwd_b[ls=%0d]", ls[i]), fb_o[i], src_sel(i, ex.s2, ex.u2));
      chk($sformatf("fwd_mem[ls=%0d]", ls[i]), {1'b0, fm_o[i]}, {1'b0, e_fm});
      last_stall |= e_stall;
      if (!r) begin
        pipe[i][0] = '0; pipe[i][1] = '0; pipe[i][2] = '0;
        stall_left[i] = 0;
      end else begin
        pipe[i][2] = mem;
        pipe[i][1] = ex;
        pipe[i][0] = (in.v && !e_stall && !f) ? in : '0;
        if (f)                    stall_left[i] = 0;
        else if (stall_left[i] > 0) stall_left[i]--;
        else if (hz && in.v)      stall_left[i] = ls[i] - 1;
      end
    end
  endtask

  // Hold the instruction in ID until no instance stalls it (bounded).
  task automatic issue(rec_t in);
    int tries = 0;
    do begin
      step(1'b1, 1'b0, in);
      tries++;
    end while (last_stall && tries < 8);
    if (last_stall) begin
      n_cmp++;
      assert (!last_stall) else begin
        n_fail++;
        $error("FAIL issue_bound observed=stalled expected=released");
      end
    end
  endtask

  task automatic nops(int n);
    for (int k = 0; k < n; k++) issue('0);
  endtask

  initial begin
    rec_t cur;
    for (int i = 0; i < 2; i++) begin
      pipe[i][0] = '0; pipe[i][1] = '0; pipe[i][2] = '0;
      stall_left[i] = 0;
    end
    step(1'b0, 1'b0, '0);
    step(1'b0, 1'b0, '0);
    // back-to-back ALU dependency: MEM forwarding
    issue(alu(3, 1, 2)); issue(alu(4, 3, 5)); nops(3);
    // one-gap dependency: WB forwarding on both operands
    issue(alu(3, 1, 2)); issue('0); issue(alu(4, 3, 3)); nops(3);
    // two producers of r3: the younger (MEM) wins
    issue(alu(3, 1, 2)); issue(alu(3, 5, 6)); issue(alu(4, 3, 3)); nops(3);
    // load-use on ALU operands
    issue(ld(2, 1)); issue(alu(1, 2, 2)); nops(4);
    // load then store of the loaded value
    issue(ld(2, 1)); issue(st(1, 2)); nops(4);
    // r0 never forwards or stalls
    issue(alu(0, 1, 2)); issue(alu(4, 0, 0)); issue(ld(0, 1)); issue(alu(5, 0, 0)); nops(3);
    // load-use coinciding with flush
    issue(ld(2, 1)); step(1'b1, 1'b1, alu(1, 2, 2)); nops(3);
    // reset in the middle of a stall, then resume
    issue(ld(2, 1)); step(1'b1, 1'b0, alu(1, 2, 2)); step(1'b0, 1'b0, alu(1, 2, 2));
    issue(alu(1, 2, 2)); issue(ld(2, 1)); issue(alu(1, 2, 2)); nops(3);
    // randomized stream; ID holds its instruction while stalled
    cur = rnd_instr();
    for (int n = 0; n < 600; n++) begin
      logic r, f;
      r = ($urandom_range(0, 49) != 0);
      f = ($urandom_range(0, 11) == 0);
      step(r, f, cur);
      if (!last_stall || f || !r) cur = rnd_instr();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
